// File: rtl/audio_streamer_pkg.sv
// audio_streamer_pkg: shared state type, bus constants and sample field slices for the streamer.
package audio_streamer_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;
  localparam logic [3:0] BYTEENABLE = 4'hF;
  localparam int LEFT_MSB = 31;
  localparam int LEFT_LSB = 16;
  localparam int RIGHT_MSB = 15;
  localparam int RIGHT_LSB = 0;
  localparam int SAMPLE_W = 16;
endpackage

// File: rtl/streamer_fifo.sv
// streamer_fifo: synchronous FIFO with flush, occupancy count and first-word-fall-through read data.
module streamer_fifo
  import audio_streamer_pkg::*;
#(
  parameter int W = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign empty_o = count_q == '0;
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];
  assign count_o = count_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/audio_sample_streamer.sv
// audio_sample_streamer: Avalon-MM read master streaming stereo words from sample memory to the codec.
// Define AUDIO_STREAMER_MUTE_ON_UNDERRUN_EN to force silent output after an underrun.
module audio_sample_streamer
  import audio_streamer_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic                loop,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   length,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [3:0]          avm_byteenable,
  output logic                avm_clken,
  input  logic [31:0]         avm_readdata,
  input  logic                sample_req,
  output logic [SAMPLE_W-1:0] sample_left,
  output logic [SAMPLE_W-1:0] sample_right,
  output logic                sample_valid,
  output logic                busy,
  output logic                done,
  output logic                underrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, len_q, len_d, rd_ptr_q, rd_ptr_d, rem_q, rem_d;
  logic loop_q, loop_d, done_q, done_d, underrun_q, underrun_d, valid_q;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [SAMPLE_W-1:0] left_q, left_d, right_q, right_d;
  logic [31:0] fifo_rdata;
  logic [AW:0] fifo_count;
  logic fifo_empty, fifo_full;
  logic [AW+1:0] occ;
  logic issue, pop, starve, accept, last, mute;
`ifdef AUDIO_STREAMER_MUTE_ON_UNDERRUN_EN
  assign mute = 1'b1;
`else
  assign mute = 1'b0;
`endif
  // Words already buffered plus words still on the bus bound how many more may be requested.
  always_comb begin
    occ = (AW+2)'(fifo_count);
    for (int i = 0; i < RD_LATENCY; i++) occ = occ + (AW+2)'(vld_q[i]);
  end
  assign issue = (state_q == FETCH) && !fifo_full && (occ < (AW+2)'(FIFO_DEPTH));
  assign pop = sample_req && (state_q != IDLE) && !fifo_empty && !stop;
  assign starve = sample_req && (state_q != IDLE) && fifo_empty && !stop;
  assign accept = (state_q == IDLE) && start && !stop;
  assign last = rem_q == ADDR_W'(1);
  if (RD_LATENCY == 1) begin : g_sh
    assign vld_d = stop ? '0 : issue;
  end else begin : g_sh
    assign vld_d = stop ? '0 : {vld_q[RD_LATENCY-2:0], issue};
  end
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    len_d = len_q;
    loop_d = loop_q;
    rd_ptr_d = rd_ptr_q;
    rem_d = rem_q;
    done_d = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          base_d = base_addr;
          len_d = length;
          loop_d = loop;
          rd_ptr_d = base_addr;
          rem_d = length;
          done_d = length == '0;
          state_d = (length == '0) ? IDLE : FETCH;
        end
        FETCH: if (issue) begin
          rd_ptr_d = (last && loop_q) ? base_q : rd_ptr_q + 1'b1;
          rem_d = (last && loop_q) ? len_q : rem_q - 1'b1;
          state_d = (last && !loop_q) ? DRAIN : FETCH;
        end
        DRAIN: if (occ == '0) begin
          done_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    left_d = pop ? fifo_rdata[LEFT_MSB:LEFT_LSB] : (starve && mute) ? '0 : left_q;
    right_d = pop ? fifo_rdata[RIGHT_MSB:RIGHT_LSB] : (starve && mute) ? '0 : right_q;
    underrun_d = starve || (underrun_q && !accept);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      base_q <= '0;
      len_q <= '0;
      loop_q <= 1'b0;
      rd_ptr_q <= '0;
      rem_q <= '0;
      vld_q <= '0;
      left_q <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      len_q <= len_d;
      loop_q <= loop_d;
      rd_ptr_q <= rd_ptr_d;
      rem_q <= rem_d;
      vld_q <= vld_d;
      left_q <= left_d;
      right_q <= right_d;
      valid_q <= pop;
      done_q <= done_d;
      underrun_q <= underrun_d;
    end
  end
  streamer_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (vld_q[RD_LATENCY-1]),
    .pop_i   (pop),
    .flush_i (stop),
    .wdata_i (avm_readdata),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );
  assign avm_address = rd_ptr_q;
  assign avm_chipselect = issue;
  assign avm_write = 1'b0;
  assign avm_byteenable = BYTEENABLE;
  assign avm_clken = 1'b1;
  assign sample_left = left_q;
  assign sample_right = right_q;
  assign sample_valid = valid_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_audio_sample_streamer.sv
// tb_audio_sample_streamer: randomized and directed bench for audio_sample_streamer against a transaction-level model.
module tb_audio_sample_streamer;
  localparam int DEPTH = 8;
  localparam int LAT = 1;
`ifdef AUDIO_STREAMER_MUTE_ON_UNDERRUN_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0, stop = 1'b0, loop = 1'b0, sample_req = 1'b0;
  logic [15:0] base_addr = '0, length = '0;
  logic [15:0] avm_address, sample_left, sample_right;
  logic avm_chipselect, avm_write, avm_clken, sample_valid, busy, done, underrun;
  logic [3:0] avm_byteenable;
  logic [31:0] avm_readdata;
  logic [15:0] mbase = '0, mem_addr_q = '0;
  typedef struct { logic [31:0] d; int c; } pend_t;
  pend_t pend[$];
  logic [31:0] fq[$];
  logic [15:0] addr_log[$];
  bit m_busy, m_fetch, m_loop, m_valid, m_done, m_ur;
  logic [15:0] m_addr, m_rem, m_base, m_len, m_left, m_right;
  int cyc = 0, cs_cnt = 0, done_cnt = 0, n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  audio_sample_streamer #(.ADDR_W(16), .FIFO_DEPTH(DEPTH), .RD_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop(loop),
    .base_addr(base_addr), .length(length), .avm_address(avm_address),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write), .avm_byteenable(avm_byteenable),
    .avm_clken(avm_clken), .avm_readdata(avm_readdata), .sample_req(sample_req),
    .sample_left(sample_left), .sample_right(sample_right), .sample_valid(sample_valid),
    .busy(busy), .done(done), .underrun(underrun)
  );

  function automatic logic [31:0] word(input logic [15:0] a, input logic [15:0] mb);
    logic [15:0] k;
    k = a - mb;
    return {k * 16'd2 + 16'd1, k * 16'd2 + 16'd2};
  endfunction

  // Sample memory: registered address, combinational data.
  always @(posedge clk) mem_addr_q <= avm_address;
  assign avm_readdata = word(mem_addr_q, mbase);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    m_busy = 0; m_fetch = 0; m_loop = 0; m_valid = 0; m_done = 0; m_ur = 0;
    m_addr = '0; m_rem = '0; m_base = '0; m_len = '0; m_left = '0; m_right = '0;
    fq.delete();
    pend.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, 64'({avm_address, avm_chipselect, avm_write, avm_byteenable, avm_clken,
                  sample_left, sample_right, sample_valid, busy, done, underrun}),
             64'({16'h0, 1'b0, 1'b0, 4'hF, 1'b1, 32'h0, 4'h0}));
  endtask

  task automatic check_outs();
    bit cs;
    cs = m_fetch && (fq.size() + pend.size() < DEPTH);
    chk("cs", 64'(avm_chipselect), 64'(cs));
    if (cs) chk("addr", 64'(avm_address), 64'(m_addr));
    chk("flags{busy,valid,done,ur}", 64'({busy, sample_valid, done, underrun}),
        64'({m_busy, m_valid, m_done, m_ur}));
    chk("sample", 64'({sample_left, sample_right}), 64'({m_left, m_right}));
    if (avm_chipselect) begin
      cs_cnt++;
      addr_log.push_back(avm_address);
    end
    if (done) done_cnt++;
  endtask

  // One clock of the reference model: words become poppable LAT cycles after issue; at most DEPTH outstanding.
  task automatic tick();
    bit cs, drain, pop, ur;
    int occ;
    pend_t p;
    occ = fq.size() + pend.size();
    cs = m_fetch && occ < DEPTH;
    drain = m_busy && !m_fetch && occ == 0;
    pop = m_busy && sample_req && !stop && fq.size() > 0;
    ur = m_busy && sample_req && !stop && fq.size() == 0;
    @(posedge clk);
    m_valid = pop;
    m_done = 0;
    if (pop) {m_left, m_right} = fq.pop_front();
    if (ur) begin
      m_ur = 1;
      if (MUTE) {m_left, m_right} = 32'h0;
    end
    if (stop) begin
      m_busy = 0;
      m_fetch = 0;
      fq.delete();
      pend.delete();
    end else begin
      while (pend.size() > 0 && pend[0].c + LAT == cyc) begin
        p = pend.pop_front();
        fq.push_back(p.d);
      end
      if (cs) begin
        pend.push_back('{word(m_addr, mbase), cyc});
        m_addr++;
        m_rem--;
        if (m_rem == 0) begin
          if (m_loop) begin
            m_addr = m_base;
            m_rem = m_len;
          end else m_fetch = 0;
        end
      end
      if (!m_busy && start) begin
        m_base = base_addr; m_len = length; m_loop = loop;
        m_addr = base_addr; m_rem = length; m_ur = 0;
        if (length == 0) m_done = 1;
        else begin
          m_busy = 1;
          m_fetch = 1;
        end
      end else if (drain) begin
        m_done = 1;
        m_busy = 0;
      end
    end
    cyc++;
    @(negedge clk);
    check_outs();
  endtask

  task automatic go(input logic [15:0] b, input logic [15:0] l, input logic lp);
    base_addr = b; length = l; loop = lp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic cycles(input int n, input int req_mod);
    for (int i = 0; i < n; i++) begin
      sample_req = 1'b0;
      if (req_mod > 0) sample_req = $urandom_range(0, req_mod - 1) == 0;
      tick();
    end
    sample_req = 1'b0;
  endtask

  task automatic wait_idle(input int req_mod);
    for (int i = 0; i < 500 && busy; i++) cycles(1, req_mod);
    chk("idle_timeout", 64'(busy), 64'(0));
  endtask

  initial begin
    logic [31:0] prev;
    logic [15:0] exp2 [4];
    exp2 = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    mreset();
    #1 reset_n = 1'b0;
    #1 chk_reset("reset_init");
    @(negedge clk);
    reset_n = 1'b1;
    check_outs();
    mbase = 16'h0010; cs_cnt = 0; done_cnt = 0;
    go(16'h0010, 16'd4, 1'b0);
    cycles(6, 0);
    for (int k = 0; k < 4; k++) begin
      sample_req = 1'b1;
      tick();
      sample_req = 1'b0;
      chk("t1_valid", 64'(sample_valid), 64'(1));
      chk("t1_lr", 64'({sample_left, sample_right}), 64'({16'(2 * k + 1), 16'(2 * k + 2)}));
      cycles(2, 0);
    end
    wait_idle(0);
    chk("t1_cs_cnt", 64'(cs_cnt), 64'(4));
    chk("t1_done_cnt", 64'(done_cnt), 64'(1));
    mbase = '0;
    addr_log.delete();
    go(16'hFFFE, 16'd4, 1'b0);
    wait_idle(1);
    chk("t2_n_addr", 64'(addr_log.size()), 64'(4));
    for (int k = 0; k < addr_log.size() && k < 4; k++) chk("t2_addr", 64'(addr_log[k]), 64'(exp2[k]));
    addr_log.delete();
    cs_cnt = 0;
    go(16'h0100, 16'd3, 1'b1);
    cycles(20, 0);
    chk("t3_cs_cnt", 64'(cs_cnt), 64'(DEPTH));
    for (int k = 0; k < addr_log.size() && k < DEPTH; k++)
      chk("t3_addr", 64'(addr_log[k]), 64'(16'h0100 + 16'(k % 3)));
    cycles(1, 1);
    cycles(4, 0);
    chk("t3_cs_after_pop", 64'(cs_cnt), 64'(DEPTH + 1));
    stop = 1'b1; tick(); stop = 1'b0;
    chk("t3_stop_busy", 64'(busy), 64'(0));
    prev = {m_left, m_right};
    go(16'h0200, 16'd6, 1'b0);
    cycles(1, 1);
    chk("t4_underrun", 64'(underrun), 64'(1));
    chk("t4_no_valid", 64'(sample_valid), 64'(0));
    chk("t4_out", 64'({sample_left, sample_right}), 64'(MUTE ? 32'h0 : prev));
    wait_idle(2);
    chk("t4_sticky", 64'(underrun), 64'(1));
    go(16'h0210, 16'd2, 1'b0);
    chk("t4_cleared", 64'(underrun), 64'(0));
    wait_idle(2);
    done_cnt = 0;
    go(16'h0300, 16'd8, 1'b0);
    cycles(5, 0);
    chk("t5_cs_at_stop", 64'(avm_chipselect), 64'(1));
    stop = 1'b1; tick(); stop = 1'b0;
    chk("t5_busy", 64'(busy), 64'(0));
    cycles(3, 0);
    chk("t5_no_done", 64'(done_cnt), 64'(0));
    cycles(1, 1);
    chk("t5_idle_req", 64'(sample_valid), 64'(0));
    go(16'h0350, 16'd1, 1'b0);
    cycles(4, 0);
    cycles(1, 1);
    chk("t5_fresh", 64'({sample_left, sample_right}), 64'(word(16'h0350, mbase)));
    wait_idle(0);
    cs_cnt = 0; done_cnt = 0;
    go(16'h0400, 16'd0, 1'b0);
    chk("t6_done", 64'(done), 64'(1));
    chk("t6_busy", 64'(busy), 64'(0));
    tick();
    chk("t6_done_pulse", 64'(done), 64'(0));
    chk("t6_cs_cnt", 64'(cs_cnt), 64'(0));
    repeat (40) begin
      go(16'($urandom), 16'($urandom_range(1, 20)), $urandom_range(0, 3) == 0);
      for (int i = 0; i < 60; i++) begin
        sample_req = 1'($urandom_range(0, 1));
        stop = $urandom_range(0, 79) == 0;
        start = $urandom_range(0, 29) == 0;
        base_addr = 16'($urandom);
        length = 16'($urandom_range(0, 12));
        loop = 1'b0;
        tick();
      end
      sample_req = 1'b0; start = 1'b0;
      stop = 1'b1; tick(); stop = 1'b0;
      wait_idle(0);
    end
    go(16'h0500, 16'd8, 1'b0);
    cycles(3, 0);
    #2 reset_n = 1'b0;
    #1 chk_reset("reset_mid_fetch");
    mreset();
    @(negedge clk);
    reset_n = 1'b1;
    check_outs();
    cycles(5, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
    $fatal(1);
  end
endmodule
